// File: rtl/pipeline_pkg.sv
// Shared types and constants for the execute-stage divider.
package pipeline_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic          ge;

  // The shifted remainder can exceed XLEN bits when the divisor has its MSB set.
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_i});
  assign rem_o  = ge ? (rem_sh[XLEN-1:0] - dvs_i) : rem_sh[XLEN-1:0];
  assign quo_o  = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/execute_divider.sv
// Iterative 32-bit RISC-V DIV/DIVU/REM/REMU unit for the execute stage.
// Optional DIV_FASTPATH_EN: finish divide-by-zero and signed overflow at the start edge.
module execute_divider
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStartE,
  input  logic            iFlushE,
  input  logic [1:0]      iDivOpE,
  input  logic [XLEN-1:0] iSrcAE,
  input  logic [XLEN-1:0] iSrcBE,
  input  logic [4:0]      iRdE,
  output logic            oBusyE,
  output logic            oDoneE,
  output logic [XLEN-1:0] oResultE,
  output logic [4:0]      oRdE
);

  div_state_t      state_q;
  div_op_t         op_q;
  logic [4:0]      rd_q, rd_out_q, cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic            qneg_q, rneg_q, dz_q, done_q;

  logic            is_signed_d, sa_d, sb_d, dz_d;
  logic [XLEN-1:0] abs_a_d, abs_b_d, rem_nx, quo_nx, res_d;

  assign is_signed_d = ~iDivOpE[0];
  assign sa_d        = is_signed_d & iSrcAE[XLEN-1];
  assign sb_d        = is_signed_d & iSrcBE[XLEN-1];
  assign abs_a_d     = sa_d ? -iSrcAE : iSrcAE;
  assign abs_b_d     = sb_d ? -iSrcBE : iSrcBE;
  assign dz_d        = (iSrcBE == '0);

`ifdef DIV_FASTPATH_EN
  logic            ovf_d, fast_hit_d;
  logic [XLEN-1:0] fast_res_d;

  assign ovf_d      = is_signed_d && (iSrcBE == '1) && (iSrcAE == {1'b1, {(XLEN-1){1'b0}}});
  assign fast_hit_d = dz_d | ovf_d;
  always_comb begin
    fast_res_d = '0;
    if (iDivOpE[1]) fast_res_d = dz_d ? iSrcAE : '0;
    else            fast_res_d = dz_d ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // A zero divisor yields an all-ones raw quotient; it must not be sign-corrected.
  always_comb begin
    res_d = '0;
    if (op_q[1]) res_d = rneg_q ? -rem_nx : rem_nx;
    else         res_d = dz_q ? '1 : (qneg_q ? -quo_nx : quo_nx);
  end

  assign oBusyE   = (state_q == RUN) || ((state_q == IDLE) && iStartE && !iFlushE);
  assign oDoneE   = done_q;
  assign oResultE = res_q;
  assign oRdE     = rd_out_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (iFlushE) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (iStartE) begin
            op_q   <= div_op_t'(iDivOpE);
            rd_q   <= iRdE;
            rem_q  <= '0;
            quo_q  <= abs_a_d;
            dvs_q  <= abs_b_d;
            qneg_q <= sa_d ^ sb_d;
            rneg_q <= sa_d;
            dz_q   <= dz_d;
            cnt_q  <= 5'(DIV_ITERS - 1);
`ifdef DIV_FASTPATH_EN
            if (fast_hit_d) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              res_q    <= fast_res_d;
              rd_out_q <= iRdE;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            res_q    <= res_d;
            rd_out_q <= rd_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_divider.sv
// Directed self-checking bench for execute_divider.
module tb_execute_divider;
  import pipeline_pkg::*;

  logic        iClk, iRst, iStartE, iFlushE;
  logic [1:0]  iDivOpE;
  logic [31:0] iSrcAE, iSrcBE;
  logic [4:0]  iRdE;
  logic        oBusyE, oDoneE;
  logic [31:0] oResultE;
  logic [4:0]  oRdE;

  int total = 0;
  int bad   = 0;

`ifdef DIV_FASTPATH_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  execute_divider #(.XLEN(32)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStartE  (iStartE),
    .iFlushE  (iFlushE),
    .iDivOpE  (iDivOpE),
    .iSrcAE   (iSrcAE),
    .iSrcBE   (iSrcBE),
    .iRdE     (iRdE),
    .oBusyE   (oBusyE),
    .oDoneE   (oDoneE),
    .oResultE (oResultE),
    .oRdE     (oRdE)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds start high until the done pulse appears.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int n = 0;
    int busy = 0;
    iDivOpE = op; iSrcAE = a; iSrcBE = b; iRdE = rd; iStartE = 1'b1;
    #1;
    while (!oDoneE && n < 200) begin
      if (oBusyE) busy++;
      @(negedge iClk);
      n++;
    end
    check({tag, ".done"}, 32'(oDoneE), 32'd1);
    check({tag, ".lat"}, busy, lat);
    check({tag, ".res"}, oResultE, exp);
    check({tag, ".rd"}, 32'(oRdE), 32'(rd));
    check({tag, ".busy_done"}, 32'(oBusyE), 32'd0);
    iStartE = 1'b0;
    @(negedge iClk);
    check({tag, ".pulse"}, 32'(oDoneE), 32'd0);
  endtask

  initial begin
    int seen;
    iRst = 1'b1; iStartE = 1'b0; iFlushE = 1'b0;
    iDivOpE = '0; iSrcAE = '0; iSrcBE = '0; iRdE = '0;
    repeat (2) @(negedge iClk);
    check("rst.busy", 32'(oBusyE), 32'd0);
    check("rst.done", 32'(oDoneE), 32'd0);
    check("rst.res", oResultE, 32'd0);
    check("rst.rd", 32'(oRdE), 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33);
    run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFD,   33);
    run_op("rem_m7_2",     OP_REM,  32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFF,   33);
    run_op("remu_7_big",   OP_REMU, 32'd7,          32'hFFFFFFFE,   5'd8,  32'd7,          33);
    run_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFFFFFE,   5'd9,  32'hFFFFFFFD,   33);
    run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFFFFFE,   5'd10, 32'd1,          33);
    run_op("rem_m7_m2",    OP_REM,  32'hFFFFFFF9,   32'hFFFFFFFE,   5'd11, 32'hFFFFFFFF,   33);
    run_op("divu_wide",    OP_DIVU, 32'hFFFFFFFF,   32'h80000001,   5'd12, 32'd1,          33);
    run_op("remu_wide",    OP_REMU, 32'hFFFFFFFF,   32'h80000001,   5'd13, 32'h7FFFFFFE,   33);
    run_op("div_5_0",      OP_DIV,  32'd5,          32'd0,          5'd14, 32'hFFFFFFFF,   SPL);
    run_op("rem_5_0",      OP_REM,  32'd5,          32'd0,          5'd15, 32'd5,          SPL);
    run_op("div_m5_0",     OP_DIV,  32'hFFFFFFFB,   32'd0,          5'd16, 32'hFFFFFFFF,   SPL);
    run_op("rem_m5_0",     OP_REM,  32'hFFFFFFFB,   32'd0,          5'd17, 32'hFFFFFFFB,   SPL);
    run_op("divu_5_0",     OP_DIVU, 32'd5,          32'd0,          5'd18, 32'hFFFFFFFF,   SPL);
    run_op("div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd19, 32'h80000000,   SPL);
    run_op("rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF,   5'd20, 32'd0,          SPL);
    run_op("divu_big_3",   OP_DIVU, 32'hFFFFFFFF,   32'd3,          5'd21, 32'h55555555,   33);

    // Flush in the middle of RUN: no pulse, outputs keep the previous result.
    iDivOpE = OP_DIVU; iSrcAE = 32'd1000; iSrcBE = 32'd10; iRdE = 5'd30; iStartE = 1'b1;
    repeat (11) @(negedge iClk);
    check("flush.busy_run", 32'(oBusyE), 32'd1);
    iFlushE = 1'b1;
    @(negedge iClk);
    iFlushE = 1'b0; iStartE = 1'b0;
    #1;
    check("flush.busy", 32'(oBusyE), 32'd0);
    check("flush.done", 32'(oDoneE), 32'd0);
    check("flush.res", oResultE, 32'h55555555);
    check("flush.rd", 32'(oRdE), 32'd21);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (oDoneE) seen++;
    end
    check("flush.no_pulse", seen, 0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);

    // Flush and start together in IDLE: flush wins.
    iDivOpE = OP_DIVU; iSrcAE = 32'd50; iSrcBE = 32'd5; iRdE = 5'd2;
    iStartE = 1'b1; iFlushE = 1'b1;
    #1;
    check("flstart.busy", 32'(oBusyE), 32'd0);
    @(negedge iClk);
    iStartE = 1'b0; iFlushE = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (oDoneE || oBusyE) seen++;
    end
    check("flstart.idle", seen, 0);
    check("flstart.res", oResultE, 32'd3);

    // Asynchronous reset mid-RUN.
    iDivOpE = OP_DIVU; iSrcAE = 32'd100; iSrcBE = 32'd7; iRdE = 5'd3; iStartE = 1'b1;
    repeat (6) @(negedge iClk);
    #2;
    iRst = 1'b1; iStartE = 1'b0;
    #1;
    check("arst.busy", 32'(oBusyE), 32'd0);
    check("arst.done", 32'(oDoneE), 32'd0);
    check("arst.res", oResultE, 32'd0);
    check("arst.rd", 32'(oRdE), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    // Back-to-back, one IDLE cycle apart.
    run_op("b2b_a", OP_DIVU, 32'd100,      32'd7, 5'd1, 32'd14,       33);
    run_op("b2b_b", OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFD, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
